// File: rtl/ctrl_flow.sv
// ctrl_flow -- control-flow resolver between decode and the program counter.
//
// Resolves branch/jump/call/return/halt requests into the PC's branch_en,
// jump_en and Target inputs. It also provides the compare-equality flag EQ
// and the Halt freeze signal.
// Holds a writable branch-target LUT, the equality flag and (optionally)
// a return-address stack. A RUN/HALT/FAULT state machine freezes fetch.
//
// Optional feature macro: CTRL_FLOW_RAS_EN
//   defined     : return-address stack present (call pushes, ret pops)
//   not defined : no stack; call acts as jump, ret faults,
//                 rs_full=0 and rs_empty=1 constantly
//
// Ports:
//   CLK                 clock, all state changes on posedge
//   Init                asynchronous active-low reset
//   PC[8:0]             current program counter (return address source)
//   cmp_en, cmp_a/b     compare instruction and its 8-bit operands
//   br_req, jmp_req     conditional branch / unconditional jump requests
//   call_req, ret_req   call / return requests
//   halt_req, resume    enter / leave HALT
//   lut_idx             target LUT read index
//   lut_we/waddr/wdata  target LUT write port
//   branch_en, jump_en  to PC, combinational
//   Target[8:0]         to PC, combinational
//   EQ                  to PC, current compare result or stored flag
//   Halt                to PC, high in HALT and FAULT
//   rs_full, rs_empty   return-stack status
//   fault               sticky error (stack over/underflow)
module ctrl_flow #(
   parameter int RS_DEPTH = 4,
   parameter int LUT_AW   = 5
) (
   input  logic              CLK,
   input  logic              Init,
   input  logic [8:0]        PC,
   input  logic              cmp_en,
   input  logic [7:0]        cmp_a,
   input  logic [7:0]        cmp_b,
   input  logic              br_req,
   input  logic              jmp_req,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic              halt_req,
   input  logic              resume,
   input  logic [LUT_AW-1:0] lut_idx,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [8:0]        lut_wdata,
   output logic              branch_en,
   output logic              jump_en,
   output logic [8:0]        Target,
   output logic              EQ,
   output logic              Halt,
   output logic              rs_full,
   output logic              rs_empty,
   output logic              fault
);

   localparam int PW = $clog2(RS_DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic          eq_flag;
   logic          fault_q;
   logic          set_fault;
   logic          push;
   logic          pop;
   logic          br_c;
   logic          jmp_c;
   logic [8:0]    tgt_c;
   logic          cmp_eq;
   logic [8:0]    lut_rd;
   logic [8:0]    lut_mem [0:(1<<LUT_AW)-1];
   logic [PW-1:0] rs_cnt;
   logic [8:0]    rs_top;
   logic          rs_is_full;
   logic          rs_is_empty;

   // ---------------------------------------------------------------
   // Target LUT: no reset, synchronous write, asynchronous read, so a
   // same-cycle read of the written index sees the old contents.
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (lut_we) begin
         lut_mem[lut_waddr] <= lut_wdata;
      end
   end

   assign lut_rd = lut_mem[lut_idx];

   // ---------------------------------------------------------------
   // Return-address stack
   // ---------------------------------------------------------------
`ifdef CTRL_FLOW_RAS_EN
   localparam int IW = $clog2(RS_DEPTH);

   logic [8:0] rs_mem [0:RS_DEPTH-1];

   assign rs_is_full  = (rs_cnt == PW'(RS_DEPTH));
   assign rs_is_empty = (rs_cnt == '0);
   // Only consumed when the stack is non-empty, so the wrap at count 0 is harmless.
   assign rs_top      = rs_mem[IW'(rs_cnt - PW'(1))];

   always_ff @(posedge CLK or negedge Init) begin
      if (!Init) begin
         rs_cnt <= '0;
      end else if (push) begin
         rs_cnt <= rs_cnt + PW'(1);
      end else if (pop) begin
         rs_cnt <= rs_cnt - PW'(1);
      end
   end

   // Return address wraps 511 -> 0 through the 9-bit add.
   always_ff @(posedge CLK) begin
      if (push) begin
         rs_mem[IW'(rs_cnt)] <= PC + 9'd1;
      end
   end
`else
   logic unused_ras;

   assign rs_cnt      = '0;
   assign rs_top      = '0;
   assign rs_is_full  = 1'b0;
   assign rs_is_empty = (rs_cnt == '0);
   assign unused_ras  = ^{PC, push, pop, rs_top};
`endif

   // ---------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge CLK or negedge Init) begin
      if (!Init) begin
         state   <= ST_RUN;
         eq_flag <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (cmp_en) begin
            eq_flag <= cmp_eq;
         end
         if (set_fault) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign cmp_eq = (cmp_a == cmp_b);

   // ---------------------------------------------------------------
   // Control FSM: next state and request resolution
   // Only the highest-priority request in RUN is honoured.
   // ---------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      br_c      = 1'b0;
      jmp_c     = 1'b0;
      tgt_c     = lut_rd;
      push      = 1'b0;
      pop       = 1'b0;
      set_fault = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (halt_req) begin
               state_nx = ST_HALT;
            end else if (ret_req) begin
`ifdef CTRL_FLOW_RAS_EN
               if (rs_is_empty) begin
                  state_nx  = ST_FAULT;
                  set_fault = 1'b1;
               end else begin
                  jmp_c = 1'b1;
                  tgt_c = rs_top;
                  pop   = 1'b1;
               end
`else
               state_nx  = ST_FAULT;
               set_fault = 1'b1;
`endif
            end else if (call_req) begin
`ifdef CTRL_FLOW_RAS_EN
               if (rs_is_full) begin
                  state_nx  = ST_FAULT;
                  set_fault = 1'b1;
               end else begin
                  jmp_c = 1'b1;
                  push  = 1'b1;
               end
`else
               jmp_c = 1'b1;
`endif
            end else if (jmp_req) begin
               jmp_c = 1'b1;
            end else if (br_req) begin
               br_c = 1'b1;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_nx = ST_RUN;
            end
         end
         ST_FAULT: begin
            state_nx = ST_FAULT;
         end
         default: begin
            state_nx = ST_FAULT;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Outputs: all forced low during reset except rs_empty.
   // ---------------------------------------------------------------
   assign branch_en = Init & br_c;
   assign jump_en   = Init & jmp_c;
   assign Target    = Init ? tgt_c : '0;
   assign EQ        = Init & (cmp_en ? cmp_eq : eq_flag);
   assign Halt      = Init & (state != ST_RUN);
   assign rs_full   = Init & rs_is_full;
   assign rs_empty  = ~Init | rs_is_empty;
   assign fault     = Init & fault_q;

endmodule
